// File: rtl/seg_scan_ctrl_if.sv
// Write-side and decoder-ROM bus of seg_scan_ctrl.
// master = CPU writer plus the ROM that answers rom_addr; slave = the scan controller.
interface seg_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [4:0] wr_code;
  logic       wr_dp;
  logic [4:0] rom_addr;
  logic [7:0] rom_seg;

  modport master (
    output wr_en, wr_idx, wr_code, wr_dp, rom_seg,
    input  rom_addr
  );

  modport slave (
    input  wr_en, wr_idx, wr_code, wr_dp, rom_seg,
    output rom_addr
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller sharing one hex decoder ROM.
// Each slot: SETUP (ROM lookup), SCAN_DIV cycles DRIVE, GAP_CYCLES cycles dead-time.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  seg_scan_ctrl_if.slave        bus,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic                  frame_done
);

  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned CntMax = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] DriveLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);
  localparam logic [4:0]      CodeBlank = 5'd16;

  typedef enum logic [1:0] {StOff, StSetup, StDrive, StGap} state_e;

  // Digit register file
  logic [4:0]            code_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_q;

  logic            wr_hit;
  logic [IdxW-1:0] wr_sel;
  logic [4:0]      wr_code_sat;

  always_comb begin
    wr_hit      = bus.wr_en && (32'(bus.wr_idx) < NUM_DIGITS);
    wr_sel      = bus.wr_idx[IdxW-1:0];
    wr_code_sat = (bus.wr_code > CodeBlank) ? CodeBlank : bus.wr_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        code_q[i] <= CodeBlank;
      end
      dp_q <= '0;
    end else if (wr_hit) begin
      code_q[wr_sel] <= wr_code_sat;
      dp_q[wr_sel]   <= bus.wr_dp;
    end
  end

  // Scan FSM
  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic [IdxW-1:0] idx_next;
  logic [CntW-1:0] cnt_q;
  logic            dp_snap_q;

  always_comb begin
    idx_next = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StOff;
      idx_q        <= '0;
      cnt_q        <= '0;
      dp_snap_q    <= 1'b0;
      bus.rom_addr <= CodeBlank;
      seg_out      <= 8'hFF;
      an_out       <= '1;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!en) begin
        state_q <= StOff;
        idx_q   <= '0;
        cnt_q   <= '0;
        seg_out <= 8'hFF;
        an_out  <= '1;
      end else begin
        case (state_q)
          StOff: begin
            state_q      <= StSetup;
            bus.rom_addr <= code_q[0];
            dp_snap_q    <= dp_q[0];
          end
          StSetup: begin
            // dp is snapshotted with the code so a mid-slot write never tears a digit
            seg_out <= {bus.rom_seg[7:1], bus.rom_seg[0] & ~dp_snap_q};
            an_out  <= ~(NUM_DIGITS'(1) << idx_q);
            cnt_q   <= '0;
            state_q <= StDrive;
          end
          StDrive: begin
            if (cnt_q == DriveLast) begin
              seg_out <= 8'hFF;
              an_out  <= '1;
              cnt_q   <= '0;
              if (GAP_CYCLES == 0) begin
                idx_q        <= idx_next;
                bus.rom_addr <= code_q[idx_next];
                dp_snap_q    <= dp_q[idx_next];
                frame_done   <= (idx_q == IdxLast);
                state_q      <= StSetup;
              end else begin
                state_q <= StGap;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StGap: begin
            if (cnt_q == GapLast) begin
              cnt_q        <= '0;
              idx_q        <= idx_next;
              bus.rom_addr <= code_q[idx_next];
              dp_snap_q    <= dp_q[idx_next];
              frame_done   <= (idx_q == IdxLast);
              state_q      <= StSetup;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: state_q <= StOff;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: an 8-digit gapped instance and a 2-digit gapless instance.
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       en_a;
  logic       en_b;
  logic [7:0] seg_a;
  logic [7:0] seg_b;
  logic [7:0] an_a;
  logic [1:0] an_b;
  logic       fd_a;
  logic       fd_b;

  int checks = 0;
  int passes = 0;

  seg_scan_ctrl_if ifa ();
  seg_scan_ctrl_if ifb ();

  // Active-low hex decoder: bit7..1 = a..g, bit0 = dp
  function automatic logic [7:0] hex_seg(input logic [4:0] c);
    case (c)
      5'd0:  return 8'b0000_0011;
      5'd1:  return 8'b1001_1111;
      5'd2:  return 8'b0010_0101;
      5'd3:  return 8'b0000_1101;
      5'd4:  return 8'b1001_1001;
      5'd5:  return 8'b0100_1001;
      5'd6:  return 8'b0100_0001;
      5'd7:  return 8'b0001_1111;
      5'd8:  return 8'b0000_0001;
      5'd9:  return 8'b0000_1001;
      5'd10: return 8'b0001_0001;
      5'd11: return 8'b1100_0001;
      5'd12: return 8'b0110_0011;
      5'd13: return 8'b1000_0101;
      5'd14: return 8'b0110_0001;
      5'd15: return 8'b0111_0001;
      default: return 8'hFF;
    endcase
  endfunction

  always_comb ifa.rom_seg = hex_seg(ifa.rom_addr);
  always_comb ifb.rom_seg = hex_seg(ifb.rom_addr);

  seg_scan_ctrl #(
    .NUM_DIGITS(8),
    .SCAN_DIV  (3),
    .GAP_CYCLES(1)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .en        (en_a),
    .bus       (ifa.slave),
    .seg_out   (seg_a),
    .an_out    (an_a),
    .frame_done(fd_a)
  );

  seg_scan_ctrl #(
    .NUM_DIGITS(2),
    .SCAN_DIV  (2),
    .GAP_CYCLES(0)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en_b),
    .bus       (ifb.slave),
    .seg_out   (seg_b),
    .an_out    (an_b),
    .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] wa_code [8] = '{5'd0, 5'd1, 5'd8, 5'd3, 5'd25, 5'd5, 5'd6, 5'd7};
  logic       wa_dp   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    en_a        = 1'b0;
    en_b        = 1'b0;
    ifa.wr_en   = 1'b0;
    ifa.wr_idx  = '0;
    ifa.wr_code = '0;
    ifa.wr_dp   = 1'b0;
    ifb.wr_en   = 1'b0;
    ifb.wr_idx  = '0;
    ifb.wr_code = '0;
    ifb.wr_dp   = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_an", an_a, 8'hFF);
    check("rst_seg", seg_a, 8'hFF);
    check("rst_rom_addr", ifa.rom_addr, 5'd16);
    check("rst_frame_done", fd_a, 1'b0);
    check("rst_an_b", an_b, 2'b11);
    step(3);
    check("idle_an", an_a, 8'hFF);
    check("idle_seg", seg_a, 8'hFF);
    check("idle_rom_addr", ifa.rom_addr, 5'd16);
    check("idle_frame_done", fd_a, 1'b0);

    // Load both register files; B gets an out-of-range write at idx 5
    for (int i = 0; i < 8; i++) begin
      ifa.wr_en   = 1'b1;
      ifa.wr_idx  = 3'(i);
      ifa.wr_code = wa_code[i];
      ifa.wr_dp   = wa_dp[i];
      ifb.wr_en   = (i < 3);
      ifb.wr_idx  = (i == 0) ? 3'd1 : (i == 1) ? 3'd5 : 3'd0;
      ifb.wr_code = (i == 0) ? 5'd2 : (i == 1) ? 5'd3 : 5'd10;
      ifb.wr_dp   = (i == 2);
      step(1);
    end
    ifa.wr_en = 1'b0;
    ifb.wr_en = 1'b0;

    // Instance A: 5-cycle slots, 40-cycle frames
    en_a = 1'b1;
    step(1);
    check("e1_rom_addr", ifa.rom_addr, 5'd0);
    check("e1_an_setup", an_a, 8'hFF);
    check("e1_no_frame_done", fd_a, 1'b0);
    step(1);
    check("e2_an_d0", an_a, 8'hFE);
    check("e2_seg_d0", seg_a, 8'h03);
    step(2);
    check("e4_an_d0_held", an_a, 8'hFE);
    step(1);
    check("e5_gap_an", an_a, 8'hFF);
    check("e5_gap_seg", seg_a, 8'hFF);
    step(1);
    check("e6_rom_addr_d1", ifa.rom_addr, 5'd1);
    check("e6_setup_an", an_a, 8'hFF);
    step(1);
    check("e7_an_d1", an_a, 8'hFD);
    check("e7_seg_d1", seg_a, 8'b1001_1111);
    step(5);
    check("e12_an_d2", an_a, 8'hFB);
    check("e12_seg_d2_dp", seg_a, 8'h00);
    step(5);
    check("e17_an_d3", an_a, 8'hF7);
    check("e17_seg_d3", seg_a, 8'h0D);
    ifa.wr_en   = 1'b1;
    ifa.wr_idx  = 3'd3;
    ifa.wr_code = 5'd9;
    ifa.wr_dp   = 1'b0;
    step(1);
    ifa.wr_en = 1'b0;
    check("e18_midwrite_seg", seg_a, 8'h0D);
    check("e18_midwrite_an", an_a, 8'hF7);
    step(4);
    check("e22_an_d4_blank", an_a, 8'hEF);
    check("e22_seg_d4_blank", seg_a, 8'hFF);
    step(18);
    check("e40_frame_done_low", fd_a, 1'b0);
    step(1);
    check("e41_frame_done", fd_a, 1'b1);
    check("e41_rom_addr", ifa.rom_addr, 5'd0);
    check("e41_an", an_a, 8'hFF);
    step(1);
    check("e42_frame_done_clr", fd_a, 1'b0);
    check("e42_an_d0", an_a, 8'hFE);
    step(15);
    check("e57_an_d3", an_a, 8'hF7);
    check("e57_seg_d3_new", seg_a, 8'b0000_1001);
    step(10);
    check("e67_an_d5", an_a, 8'hDF);
    check("e67_seg_d5", seg_a, 8'h49);
    en_a = 1'b0;
    step(1);
    check("off_an", an_a, 8'hFF);
    check("off_seg", seg_a, 8'hFF);
    check("off_frame_done", fd_a, 1'b0);
    step(1);
    check("off_an_held", an_a, 8'hFF);
    en_a = 1'b1;
    step(1);
    check("restart_rom_addr", ifa.rom_addr, 5'd0);
    check("restart_an_setup", an_a, 8'hFF);
    check("restart_no_frame_done", fd_a, 1'b0);
    step(1);
    check("restart_an_d0", an_a, 8'hFE);
    check("restart_seg_d0", seg_a, 8'h03);

    // Instance B: no gap, 3-cycle slots, out-of-range write ignored, code 25 saturates
    en_b = 1'b1;
    step(1);
    check("b1_rom_addr", ifb.rom_addr, 5'd10);
    check("b1_an", an_b, 2'b11);
    step(1);
    check("b2_an_d0", an_b, 2'b10);
    check("b2_seg_d0_dp", seg_b, 8'h10);
    step(2);
    check("b4_setup_an", an_b, 2'b11);
    check("b4_setup_seg", seg_b, 8'hFF);
    check("b4_rom_addr_d1", ifb.rom_addr, 5'd2);
    check("b4_no_frame_done", fd_b, 1'b0);
    step(1);
    check("b5_an_d1", an_b, 2'b01);
    check("b5_seg_d1", seg_b, 8'h25);
    step(2);
    check("b7_frame_done", fd_b, 1'b1);
    check("b7_rom_addr", ifb.rom_addr, 5'd10);
    check("b7_an", an_b, 2'b11);
    ifb.wr_en   = 1'b1;
    ifb.wr_idx  = 3'd1;
    ifb.wr_code = 5'd25;
    ifb.wr_dp   = 1'b0;
    step(1);
    ifb.wr_en = 1'b0;
    check("b8_frame_done_clr", fd_b, 1'b0);
    check("b8_an_d0", an_b, 2'b10);
    step(2);
    check("b10_rom_addr_sat", ifb.rom_addr, 5'd16);
    step(1);
    check("b11_an_d1", an_b, 2'b01);
    check("b11_seg_blank", seg_b, 8'hFF);

    // Reset wins over a coincident write
    rst         = 1'b1;
    ifa.wr_en   = 1'b1;
    ifa.wr_idx  = 3'd0;
    ifa.wr_code = 5'd9;
    step(1);
    rst       = 1'b0;
    ifa.wr_en = 1'b0;
    check("rst2_an", an_a, 8'hFF);
    check("rst2_seg", seg_a, 8'hFF);
    check("rst2_rom_addr", ifa.rom_addr, 5'd16);
    step(1);
    check("rst2_setup_rom_addr", ifa.rom_addr, 5'd16);
    step(1);
    check("rst2_an_d0", an_a, 8'hFE);
    check("rst2_seg_blank", seg_a, 8'hFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one hex-to-segment decoder ROM. Holds a per-digit code register file and drives the shared ROM address one digit at a time. It latches the returned active-low segment pattern and strobes the matching digit anode, with dead-time between digits to suppress ghosting. Sits between the register/CPU write side and the board display pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned (2..8)
- SCAN_DIV, 1000, cycles a digit is driven per scan slot (>=1)
- GAP_CYCLES, 4, dead-time cycles between digits, anodes all off (0 = no gap state)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  scan enable; low blanks display
- wr_en  in  1  write strobe for digit register file
- wr_idx  in  3  digit index written; indices >= NUM_DIGITS ignored
- wr_code  in  5  decoder code 0..15 hex, 16 blank; values 17..31 stored as 16
- wr_dp  in  1  decimal point on (1) for that digit
- rom_addr  out  5  address to shared decoder ROM (registered)
- rom_seg  in  8  combinational ROM data for rom_addr, active-low, bit0 = dp
- seg_out  out  8  registered segment pins, active-low
- an_out  out  NUM_DIGITS  digit anode enables, active-low, at most one low
- frame_done  out  1  one-cycle pulse after last digit's slot completes

## Operation
- Register file: NUM_DIGITS entries {code[4:0], dp}; reset to {16, 0}. Write on wr_en at clk edge.
- FSM states: OFF, SETUP, DRIVE, GAP. Counters: idx (digit), cnt (slot timer, wide enough for max(SCAN_DIV, GAP_CYCLES)).
- OFF: an_out all 1, seg_out 8'hFF, idx=0. en=1 -> SETUP, loading rom_addr <= code[0].
- SETUP (1 cycle): rom_addr stable; at edge seg_out <= {rom_seg[7:1], rom_seg[0] & ~dp[idx]}; go DRIVE, cnt=0.
- DRIVE: an_out[idx]=0; seg_out held. After SCAN_DIV cycles -> GAP (or, if GAP_CYCLES=0, directly to next digit's SETUP).
- GAP: an_out all 1, seg_out 8'hFF for GAP_CYCLES cycles. Then idx advances; rom_addr <= code[next idx]; -> SETUP.
- Wrap: idx NUM_DIGITS-1 -> 0; frame_done asserted for the single cycle in which the SETUP of digit 0 following the wrap is active.
- en low in any non-OFF state: next cycle OFF (anodes off, seg 8'hFF, idx=0, cnt=0); no frame_done.
- Write to digit currently in DRIVE: no visible change until that digit's next SETUP (code snapshot at SETUP entry).
- Write coincident with SETUP-entry load of same idx: old value used; new value next scan.
- Out-of-range wr_idx: no effect.

## Timing
- Reset values: rom_addr=16, seg_out=8'hFF, an_out all 1, frame_done=0, state OFF, idx=0, cnt=0.
- Slot period per digit = 1 + SCAN_DIV + GAP_CYCLES cycles; frame period = NUM_DIGITS x slot period.
- en rising at edge k: SETUP in cycle k+1, first anode low in cycle k+2.
- rom_addr changes only on SETUP entry; rom_seg sampled once per slot, end of SETUP.
- an_out and seg_out registered; no glitch; an_out never has two bits low.
- rst overrides everything including a coincident wr_en (write dropped).

## Test plan
- Reset then idle: rst=1 two cycles, en=0 -> an_out=8'hFF, seg_out=8'hFF, rom_addr=16, frame_done=0 held.
- Basic scan, SCAN_DIV=3, GAP_CYCLES=1, behavioural ROM: write digits 0..7 = codes 0..7, en=1 -> an_out walks FE,(FF gap),FD,... each low 3 cycles; seg_out for digit 1 = 8'b1001_1111; 5-cycle slots.
- frame_done: continuous scan -> one-cycle pulse every 40 cycles (8 x 5), coinciding with digit 0's SETUP.
- DP and blank: digit 2 = code 8, dp=1 -> seg_out 8'b0000_0000; wr_code=25 -> stored 16, seg_out 8'hFF, anode still strobed.
- Mid-slot write: during digit 3 DRIVE write code 9 -> seg_out unchanged this slot; next frame digit 3 shows 8'b0000_1001.
- en drop mid-DRIVE of digit 5 -> next cycle an_out=8'hFF, seg_out=8'hFF; en re-raised -> restart at digit 0 after one SETUP cycle; GAP_CYCLES=0 variant shows DRIVE->SETUP back-to-back.
